// File: rtl/garage_motor_scheduler_if.sv
// Door-side bundle for garage_motor_scheduler: requests and sensors in, grant/motor/status out.
// Obstruct exists only when GARAGE_OBSTRUCT_EN is defined.
interface garage_motor_scheduler_if #(parameter int N_DOORS = 4);
  logic [N_DOORS-1:0] Activate;
  logic [N_DOORS-1:0] Up_Max;
  logic [N_DOORS-1:0] Dn_Max;
  logic               Fault_Clr;
`ifdef GARAGE_OBSTRUCT_EN
  logic [N_DOORS-1:0] Obstruct;
`endif
  logic [N_DOORS-1:0] Grant;
  logic               UP_M;
  logic               DN_M;
  logic               Busy;
  logic [N_DOORS-1:0] Fault;

  modport slave (
`ifdef GARAGE_OBSTRUCT_EN
    input  Obstruct,
`endif
    input  Activate, Up_Max, Dn_Max, Fault_Clr,
    output Grant, UP_M, DN_M, Busy, Fault
  );

  modport master (
`ifdef GARAGE_OBSTRUCT_EN
    output Obstruct,
`endif
    output Activate, Up_Max, Dn_Max, Fault_Clr,
    input  Grant, UP_M, DN_M, Busy, Fault
  );
endinterface

// File: rtl/garage_motor_scheduler.sv
// Round-robin sharing of one motor drive between N_DOORS doors, with timeout faults and a rest gap.
// Optional GARAGE_OBSTRUCT_EN adds a one-shot reverse-on-obstruction during closing.
module garage_motor_scheduler #(
  parameter int N_DOORS      = 4,
  parameter int MOVE_TIMEOUT = 1000,
  parameter int GAP_CYCLES   = 4
) (
  input  logic CLK,
  input  logic RST,
  garage_motor_scheduler_if.slave bus
);
  localparam int PW = (N_DOORS > 1) ? $clog2(N_DOORS) : 1;
  localparam int CW = $clog2(MOVE_TIMEOUT + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DN, GAP} state_e;

  state_e             state_q, state_d;
  logic [N_DOORS-1:0] pend_q, pend_d, fault_q, fault_d, grant_q, grant_d;
  logic [N_DOORS-1:0] pclr, fault_set;
  logic [PW-1:0]      rr_q, rr_d, gidx_q, gidx_d, sel_idx;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [GW-1:0]      gcnt_q, gcnt_d;
  logic               up_q, up_d, dn_q, dn_d, sel_vld;
  logic               up_g, dn_g, tmo;
`ifdef GARAGE_OBSTRUCT_EN
  logic               rev_q, rev_d;
`endif

  assign up_g = bus.Up_Max[gidx_q];
  assign dn_g = bus.Dn_Max[gidx_q];
  assign tmo  = (cnt_q == CW'(MOVE_TIMEOUT - 1));

  // Walk downward so the candidate closest to rr_q is the last (winning) assignment.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int k = N_DOORS - 1; k >= 0; k--) begin
      if (pend_q[PW'((int'(rr_q) + k) % N_DOORS)]) begin
        sel_vld = 1'b1;
        sel_idx = PW'((int'(rr_q) + k) % N_DOORS);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      pend_q  <= '0;
      fault_q <= '0;
      grant_q <= '0;
      rr_q    <= '0;
      gidx_q  <= '0;
      cnt_q   <= '0;
      gcnt_q  <= '0;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
`ifdef GARAGE_OBSTRUCT_EN
      rev_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      fault_q <= fault_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      gidx_q  <= gidx_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
      up_q    <= up_d;
      dn_q    <= dn_d;
`ifdef GARAGE_OBSTRUCT_EN
      rev_q   <= rev_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    gidx_d    = gidx_q;
    cnt_d     = cnt_q;
    gcnt_d    = gcnt_q;
    pclr      = '0;
    fault_set = '0;
`ifdef GARAGE_OBSTRUCT_EN
    rev_d     = rev_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (sel_vld) begin
          gidx_d        = sel_idx;
          rr_d          = (sel_idx == PW'(N_DOORS - 1)) ? '0 : sel_idx + 1'b1;
          cnt_d         = '0;
          pclr[sel_idx] = 1'b1;
`ifdef GARAGE_OBSTRUCT_EN
          rev_d         = 1'b0;
`endif
          // Both limits at once means a broken sensor: never drive into it.
          if (bus.Up_Max[sel_idx] && bus.Dn_Max[sel_idx]) begin
            fault_set[sel_idx] = 1'b1;
            state_d            = GAP;
            gcnt_d             = '0;
          end else if (bus.Up_Max[sel_idx]) begin
            state_d = MOVE_DN;
          end else begin
            state_d = MOVE_UP;
          end
        end
      end
      MOVE_UP: begin
        cnt_d = (cnt_q == CW'(MOVE_TIMEOUT)) ? cnt_q : cnt_q + 1'b1;
        if (up_g || tmo) begin
          state_d = GAP;
          gcnt_d  = '0;
          if (dn_g || tmo) fault_set[gidx_q] = 1'b1;
        end
      end
      MOVE_DN: begin
        cnt_d = (cnt_q == CW'(MOVE_TIMEOUT)) ? cnt_q : cnt_q + 1'b1;
        if (dn_g || tmo) begin
          state_d = GAP;
          gcnt_d  = '0;
          if (up_g || tmo) fault_set[gidx_q] = 1'b1;
        end
`ifdef GARAGE_OBSTRUCT_EN
        else if (bus.Obstruct[gidx_q] && !rev_q) begin
          state_d = MOVE_UP;
          rev_d   = 1'b1;
        end
`endif
      end
      GAP: begin
        if (gcnt_q == GW'(GAP_CYCLES - 1)) state_d = IDLE;
        else                               gcnt_d  = gcnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_d = '0;
    if (state_d == MOVE_UP || state_d == MOVE_DN) grant_d[gidx_d] = 1'b1;
    up_d = (state_d == MOVE_UP);
    dn_d = (state_d == MOVE_DN);
  end

  // Selection clear beats a same-edge re-request; a fault set beats Fault_Clr.
  assign pend_d  = ~pclr & (pend_q | (bus.Activate & ~fault_q & ~grant_q));
  assign fault_d = (fault_q & ~{N_DOORS{bus.Fault_Clr}}) | fault_set;

  assign bus.Grant = grant_q;
  assign bus.UP_M  = up_q;
  assign bus.DN_M  = dn_q;
  assign bus.Busy  = (state_q != IDLE);
  assign bus.Fault = fault_q;
endmodule

// File: tb/tb_garage_motor_scheduler.sv
// Directed test-plan walk plus randomized door traffic, checked against a transaction-level model.
module tb_garage_motor_scheduler;
  localparam int N   = 4;
  localparam int TO  = 16;
  localparam int GAP = 4;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  garage_motor_scheduler_if #(.N_DOORS(N)) bus ();
  garage_motor_scheduler #(.N_DOORS(N), .MOVE_TIMEOUT(TO), .GAP_CYCLES(GAP)) dut (
    .CLK(CLK), .RST(RST), .bus(bus)
  );

  int errs = 0, checks = 0;

  // Model state: which door is moving, in what direction (0 none, 1 up, 2 down), for how long.
  logic [N-1:0] m_pend, m_fault;
  int m_rr, m_door, m_dir, m_moved, m_gap;
  bit m_rev;
  bit phys, phys_rand;
  int travel;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_fault = '0; m_rr = 0; m_door = 0; m_dir = 0;
    m_moved = 0; m_gap = 0; m_rev = 0;
  endtask

  task automatic model_step();
    logic [N-1:0] act, up, dn, obs, fset, pclr;
    int g_old, g, sel;
    bit hit, found;
    act = bus.Activate; up = bus.Up_Max; dn = bus.Dn_Max;
    obs = '0;
`ifdef GARAGE_OBSTRUCT_EN
    obs = bus.Obstruct;
`endif
    fset = '0; pclr = '0;
    g_old = (m_dir != 0) ? m_door : -1;
    if (m_dir != 0) begin
      g = m_door;
      m_moved++;
      hit = (m_dir == 1) ? up[g] : dn[g];
      if (hit || m_moved >= TO) begin
        if ((up[g] && dn[g]) || m_moved >= TO) fset[g] = 1'b1;
        m_dir = 0;
        m_gap = GAP;
      end else if (m_dir == 2 && obs[g] && !m_rev) begin
        m_dir = 1;
        m_rev = 1;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (m_pend != '0) begin
      found = 0; sel = 0;
      for (int k = 0; k < N; k++)
        if (!found && m_pend[(m_rr + k) % N]) begin
          found = 1;
          sel = (m_rr + k) % N;
        end
      pclr[sel] = 1'b1;
      m_rr = (sel + 1) % N;
      m_door = sel; m_moved = 0; m_rev = 0;
      if (up[sel] && dn[sel]) begin
        fset[sel] = 1'b1;
        m_gap = GAP;
      end else m_dir = up[sel] ? 2 : 1;
    end
    for (int i = 0; i < N; i++) begin
      if (pclr[i]) m_pend[i] = 1'b0;
      else if (act[i] && !m_fault[i] && g_old != i) m_pend[i] = 1'b1;
    end
    m_fault = (m_fault & ~{N{bus.Fault_Clr}}) | fset;
  endtask

  // Door mechanics: leave the start limit after one cycle, reach the far limit after `travel`.
  task automatic physics();
    int g;
    if (phys && m_dir != 0) begin
      g = m_door;
      if (m_moved == 0) travel = phys_rand ? int'($urandom_range(2, TO + 3)) : 4;
      if (m_moved >= 1) begin
        if (m_dir == 1) bus.Dn_Max[g] = 1'b0; else bus.Up_Max[g] = 1'b0;
      end
      if (m_moved >= travel - 1) begin
        if (m_dir == 1) bus.Up_Max[g] = 1'b1; else bus.Dn_Max[g] = 1'b1;
      end
    end
  endtask

  task automatic cyc();
    logic [N-1:0] eg;
    physics();
    model_step();
    @(posedge CLK);
    #1;
    eg = '0;
    if (m_dir != 0) eg[m_door] = 1'b1;
    chk("grant", 32'(bus.Grant), 32'(eg));
    chk("up_m",  32'(bus.UP_M),  32'(m_dir == 1));
    chk("dn_m",  32'(bus.DN_M),  32'(m_dir == 2));
    chk("busy",  32'(bus.Busy),  32'(m_dir != 0 || m_gap > 0));
    chk("fault", 32'(bus.Fault), 32'(m_fault));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    bus.Activate = '0; bus.Up_Max = '0; bus.Dn_Max = '1; bus.Fault_Clr = 1'b0;
`ifdef GARAGE_OBSTRUCT_EN
    bus.Obstruct = '0;
`endif
    phys = 0; phys_rand = 0; travel = 4;
    model_reset();
    #12;
    chk("rst_grant", 32'(bus.Grant), 32'h0);
    chk("rst_up",    32'(bus.UP_M),  32'h0);
    chk("rst_dn",    32'(bus.DN_M),  32'h0);
    chk("rst_busy",  32'(bus.Busy),  32'h0);
    chk("rst_fault", 32'(bus.Fault), 32'h0);
    @(negedge CLK) RST = 1'b1;

    // Door 0 open -> closes, then a full gap.
    phys = 1;
    bus.Up_Max[0] = 1'b1; bus.Dn_Max[0] = 1'b0;
    bus.Activate = 4'b0001; cyc();
    bus.Activate = '0;      cyc();
    chk("t1_grant", 32'(bus.Grant), 32'h1);
    chk("t1_dn",    32'(bus.DN_M),  32'h1);
    run(3); cyc();
    chk("t1_stop_dn",    32'(bus.DN_M),  32'h0);
    chk("t1_stop_grant", 32'(bus.Grant), 32'h0);
    chk("t1_gap_busy",   32'(bus.Busy),  32'h1);
    run(3);
    chk("t1_gap_end_busy", 32'(bus.Busy), 32'h1);
    cyc();
    chk("t1_idle_busy", 32'(bus.Busy), 32'h0);

    // Two simultaneous requests, round robin from door 1.
    bus.Activate = 4'b1010; cyc();
    bus.Activate = '0;      cyc();
    chk("t2_grant1", 32'(bus.Grant), 32'h2);
    chk("t2_up1",    32'(bus.UP_M),  32'h1);
    run(3); cyc();
    chk("t2_stop1", 32'(bus.UP_M), 32'h0);
    run(4); cyc();
    chk("t2_grant3", 32'(bus.Grant), 32'h8);
    chk("t2_up3",    32'(bus.UP_M),  32'h1);
    run(8);
    bus.Activate = 4'b0011; cyc();
    bus.Activate = '0;      cyc();
    chk("t2_rr_wrap", 32'(bus.Grant), 32'h1);
    run(8); cyc();
    chk("t2_grant1_dn", 32'(bus.Grant), 32'h2);
    chk("t2_dn1",       32'(bus.DN_M),  32'h1);
    run(8);

    // Mid-travel door 2 times out.
    phys = 0;
    bus.Up_Max[2] = 1'b0; bus.Dn_Max[2] = 1'b0;
    bus.Activate = 4'b0100; cyc();
    bus.Activate = '0;      cyc();
    chk("t3_up", 32'(bus.UP_M), 32'h1);
    run(TO - 1);
    chk("t3_still_up", 32'(bus.UP_M), 32'h1);
    cyc();
    chk("t3_tmo_up",    32'(bus.UP_M),  32'h0);
    chk("t3_tmo_fault", 32'(bus.Fault), 32'h4);
    bus.Activate = 4'b0100; run(GAP + 3);
    chk("t3_ignored_busy",  32'(bus.Busy),  32'h0);
    chk("t3_ignored_grant", 32'(bus.Grant), 32'h0);
    bus.Activate = '0; bus.Fault_Clr = 1'b1; cyc();
    bus.Fault_Clr = 1'b0;
    chk("t3_clr", 32'(bus.Fault), 32'h0);
    bus.Dn_Max[2] = 1'b1;

    // Both limits active on door 0.
    bus.Up_Max[0] = 1'b1; bus.Dn_Max[0] = 1'b1;
    bus.Activate = 4'b0001; cyc();
    bus.Activate = '0;      cyc();
    chk("t4_fault", 32'(bus.Fault), 32'h1);
    chk("t4_up",    32'(bus.UP_M),  32'h0);
    chk("t4_dn",    32'(bus.DN_M),  32'h0);
    chk("t4_busy",  32'(bus.Busy),  32'h1);
    run(GAP);
    chk("t4_done", 32'(bus.Busy), 32'h0);
    bus.Fault_Clr = 1'b1; cyc(); bus.Fault_Clr = 1'b0;
    bus.Up_Max[0] = 1'b0;

    // Async reset during a close.
    bus.Up_Max[1] = 1'b1; bus.Dn_Max[1] = 1'b0;
    bus.Activate = 4'b0010; cyc();
    bus.Activate = '0;      cyc();
    chk("t5_dn", 32'(bus.DN_M), 32'h1);
    run(1);
    #3 RST = 1'b0;
    #1;
    chk("t5_rst_dn",    32'(bus.DN_M),  32'h0);
    chk("t5_rst_grant", 32'(bus.Grant), 32'h0);
    chk("t5_rst_busy",  32'(bus.Busy),  32'h0);
    model_reset();
    @(negedge CLK) RST = 1'b1;

`ifdef GARAGE_OBSTRUCT_EN
    bus.Activate = 4'b0010; cyc();
    bus.Activate = '0;      cyc();
    bus.Up_Max[1] = 1'b0;   cyc();
    bus.Obstruct[1] = 1'b1; cyc();
    chk("ob_dn",    32'(bus.DN_M),  32'h0);
    chk("ob_up",    32'(bus.UP_M),  32'h1);
    chk("ob_grant", 32'(bus.Grant), 32'h2);
    bus.Obstruct[1] = 1'b0; cyc();
    bus.Obstruct[1] = 1'b1; cyc();
    bus.Obstruct[1] = 1'b0;
    chk("ob_second", 32'(bus.UP_M), 32'h1);
    bus.Up_Max[1] = 1'b1; cyc();
    chk("ob_end_up",    32'(bus.UP_M),  32'h0);
    chk("ob_end_grant", 32'(bus.Grant), 32'h0);
    run(GAP);
`endif

    // Random traffic with random travel lengths, sensor changes and fault clears.
    phys = 1; phys_rand = 1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) bus.Activate[i] = ($urandom_range(0, 7) == 0);
      bus.Fault_Clr = ($urandom_range(0, 31) == 0);
`ifdef GARAGE_OBSTRUCT_EN
      for (int i = 0; i < N; i++) bus.Obstruct[i] = ($urandom_range(0, 15) == 0);
`endif
      if ($urandom_range(0, 49) == 0) begin
        int d, r;
        d = int'($urandom_range(0, N - 1));
        r = int'($urandom_range(0, 9));
        if (!(m_dir != 0 && m_door == d)) begin
          bus.Up_Max[d] = (r < 4 || r == 9);
          bus.Dn_Max[d] = ((r >= 4 && r < 8) || r == 9);
        end
      end
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
